// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants, sample type and slot bit selector
//
// Purpose: constants and helpers shared by the I2S speaker transmit path.
// Ports: none (package).

package i2s_pkg;

    localparam int I2S_FRAME_BITS    = 64;
    localparam int I2S_SLOT_BITS     = 32;
    localparam int AUDIO_SAMPLE_BITS = 16;

    typedef logic signed [AUDIO_SAMPLE_BITS-1:0] audio_sample_t;

    // Serial data bit for frame position b. The sample occupies positions
    // 1..16 of each 32-bit slot, leaving a one-bit delay after WS changes and
    // zero padding in the rest of the slot.
    function automatic logic i2s_sd_bit(input audio_sample_t s, input logic [5:0] b);
        logic [3:0] idx;
        logic       bitv;
        idx  = '0;
        bitv = 1'b0;
        if (b >= 6'd1 && b <= 6'd16) begin
            idx  = 4'(6'd16 - b);
            bitv = s[idx];
        end else if (b >= 6'(I2S_SLOT_BITS + 1) && b <= 6'(I2S_SLOT_BITS + 16)) begin
            idx  = 4'(6'(I2S_SLOT_BITS + 16) - b);
            bitv = s[idx];
        end
        return bitv;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with registered occupancy
//
// Purpose: small synchronous FIFO. The head word is read from storage, so a
// word pushed into an empty FIFO is not visible until the following cycle.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_push, i_push_data : write strobe and data (ignored when full)
//   i_pop               : remove head word (ignored when empty)
//   o_head              : current head word
//   o_full, o_empty     : occupancy flags derived from the registered count

module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_speaker_tx.sv
// rtl/i2s_speaker_tx.sv - mono sample stream to Philips I2S speaker link
//
// Purpose: buffers signed 16-bit samples and sends each one on both I2S
// channels, generating SCK and WS locally from the system clock.
// Configuration macro: SPK_UNDERRUN_HOLD_EN (defined: repeat last sample on
// underrun; undefined: send silence).
// Ports:
//   clk_in, rst_in          : system clock, synchronous active-high reset
//   audio_data, audio_valid : sample input stream
//   audio_ready             : FIFO has room (low during reset)
//   spk_sck, spk_ws, spk_sd : I2S bit clock, word select, serial data
//   underrun                : one-cycle pulse when a frame starts with no sample

module i2s_speaker_tx
    import i2s_pkg::*;
#(
    parameter int SCK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic signed [AUDIO_SAMPLE_BITS-1:0] audio_data,
    input  logic                                audio_valid,
    output logic                                audio_ready,
    output logic                                spk_sck,
    output logic                                spk_ws,
    output logic                                spk_sd,
    output logic                                underrun
);

    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = $clog2(I2S_FRAME_BITS);

    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_sck;
    logic             r_ws;
    logic             r_sd;
    logic             r_underrun;
    logic             r_in_reset;
    audio_sample_t    r_tx_sample;

    logic                         w_div_wrap;
    logic                         w_fall;
    logic [BIT_W-1:0]             w_bit_next;
    logic                         w_frame_start;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic [AUDIO_SAMPLE_BITS-1:0] w_head;

    assign w_div_wrap    = (r_div_cnt == DIV_W'(SCK_DIV - 1));
    assign w_fall        = w_div_wrap && r_sck;
    assign w_bit_next    = r_bit_cnt + BIT_W'(1);
    assign w_frame_start = w_fall && (w_bit_next == '0);

    // r_in_reset keeps ready low for the reset cycles themselves, since the
    // FIFO count alone would already read "not full" while reset is held.
    assign audio_ready = !w_full && !r_in_reset;
    assign w_push      = audio_valid && audio_ready;
    assign w_pop       = w_frame_start && !w_empty;

    assign spk_sck  = r_sck;
    assign spk_ws   = r_ws;
    assign spk_sd   = r_sd;
    assign underrun = r_underrun;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AUDIO_SAMPLE_BITS)
    ) u_fifo (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_push      (w_push),
        .i_push_data (audio_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk_in) begin
        r_in_reset <= rst_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_cnt   <= '0;
            r_bit_cnt   <= '1;
            r_sck       <= 1'b0;
            r_ws        <= 1'b1;
            r_sd        <= 1'b0;
            r_underrun  <= 1'b0;
            r_tx_sample <= '0;
        end else begin
            r_underrun <= 1'b0;

            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_sck     <= ~r_sck;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            // WS and SD only move on SCK falls so they are stable at every rise.
            if (w_fall) begin
                r_bit_cnt <= w_bit_next;
                r_ws      <= w_bit_next[BIT_W-1];
                r_sd      <= i2s_sd_bit(r_tx_sample, w_bit_next);
                if (w_frame_start) begin
                    if (!w_empty) begin
                        r_tx_sample <= w_head;
                    end else begin
                        r_underrun <= 1'b1;
`ifdef SPK_UNDERRUN_HOLD_EN
                        // Keep the previous sample so the last value repeats.
                        r_tx_sample <= r_tx_sample;
`else
                        r_tx_sample <= '0;
`endif
                    end
                end
            end
        end
    end

endmodule
